// File: rtl/stopwatch_ctrl_pkg.sv
// Shared encodings and helpers for the stopwatch run-control block and its
// button conditioners.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_t;

    localparam logic ENABLED  = 1'b1;
    localparam logic DISABLED = 1'b0;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_bits(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic is_counting(input sw_state_t s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_cond.sv
// Raw push-button conditioner: 2-FF synchronizer, counting debouncer and a
// registered one-cycle pulse on each rising edge of the debounced level.
module btn_cond
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned DEB_LEN = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pulse
);

    localparam int unsigned DEB_BITS = cnt_bits(DEB_LEN);

    logic                sync1_q, sync2_q;
    logic [DEB_BITS-1:0] cnt_q, cnt_d;
    logic                level_q, level_d;
    logic                level_prev_q;
    logic                pulse_q;

    // The level only flips after DEB_LEN consecutive disagreeing samples.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == DEB_BITS'(DEB_LEN - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= DISABLED;
            sync2_q      <= DISABLED;
            cnt_q        <= '0;
            level_q      <= DISABLED;
            level_prev_q <= DISABLED;
            pulse_q      <= DISABLED;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            pulse_q      <= level_q & ~level_prev_q;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run control: conditions start/clear buttons, sequences
// IDLE/RUN/PAUSE/LAP and divides the clock into the counter's increase tick.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CNT = 100000000,
    parameter int unsigned DEB_LEN = 16
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      btn_start,
    input  logic      btn_clear,
    output logic      increase,
    output logic      cnt_clr,
    output logic      disp_hold,
    output logic      running,
    output sw_state_t dbg_state
);

    localparam int unsigned DIV_BITS = cnt_bits(DIV_CNT);

    logic                p_s, p_c;
    sw_state_t           state_q, state_d;
    logic [DIV_BITS-1:0] div_q, div_d;
    logic                tick_d, clr_d;
    logic                inc_q, clr_q, hold_q, run_q;

    btn_cond #(.DEB_LEN(DEB_LEN)) u_btn_start (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_start),
        .pulse   (p_s)
    );

    btn_cond #(.DEB_LEN(DEB_LEN)) u_btn_clear (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_clear),
        .pulse   (p_c)
    );

    // Start has priority: a clear pulse in the same cycle is dropped.
    always_comb begin
        state_d = state_q;
        clr_d   = DISABLED;
        unique case (state_q)
            ST_IDLE: begin
                if (p_s)      state_d = ST_RUN;
                else if (p_c) clr_d   = ENABLED;
            end
            ST_RUN: begin
                if (p_s)      state_d = ST_PAUSE;
                else if (p_c) state_d = ST_LAP;
            end
            ST_LAP: begin
                if (p_s)      state_d = ST_PAUSE;
                else if (p_c) state_d = ST_RUN;
            end
            ST_PAUSE: begin
                if (p_s) begin
                    state_d = ST_RUN;
                end else if (p_c) begin
                    state_d = ST_IDLE;
                    clr_d   = ENABLED;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counting needs both the current and next state to be active, so the
    // edge into PAUSE neither ticks nor advances, and the remainder survives.
    always_comb begin
        div_d  = div_q;
        tick_d = DISABLED;
        if (is_counting(state_q) && is_counting(state_d)) begin
            if (div_q == DIV_BITS'(DIV_CNT - 1)) begin
                div_d  = '0;
                tick_d = ENABLED;
            end else begin
                div_d = div_q + 1'b1;
            end
        end else if ((state_q == ST_IDLE) || (state_d == ST_IDLE)) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            inc_q   <= DISABLED;
            clr_q   <= DISABLED;
            hold_q  <= DISABLED;
            run_q   <= DISABLED;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            inc_q   <= tick_d;
            clr_q   <= clr_d;
            hold_q  <= (state_d == ST_LAP);
            run_q   <= is_counting(state_d);
        end
    end

    assign increase  = inc_q;
    assign cnt_clr   = clr_q;
    assign disp_hold = hold_q;
    assign running   = run_q;
    assign dbg_state = state_q;

endmodule
